// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester bus, the ALU operand/result bus and
// the response bus shared between the requesters/ALU and the arbiter.
//   master : requesters + ALU side (drives requests, operands and alu_c)
//   slave  : arbiter side (drives grants, ALU operands and responses)
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int TW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*W-1:0]  req_a;
  logic [NREQ*W-1:0]  req_b;
  logic [NREQ*TW-1:0] req_type;
  logic [NREQ-1:0]    gnt;
  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [TW-1:0]      alu_type;
  logic               alu_valid;
  logic [W-1:0]       alu_c;
  logic [NREQ-1:0]    rsp_valid;
  logic [W-1:0]       rsp_data;

  modport master (
    output req, req_a, req_b, req_type, alu_c,
    input  gnt, alu_a, alu_b, alu_type, alu_valid, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_a, req_b, req_type, alu_c,
    output gnt, alu_a, alu_b, alu_type, alu_valid, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU of latency LAT among NREQ requesters.
// One operation in flight at a time (IDLE/BUSY). Default arbitration is
// round-robin starting after the last winner; defining the macro
// ALU_ARBITER_FIXED_PRIO_EN switches to fixed priority (lowest index wins).
// Reset (rst) is synchronous, active-high, and aborts any operation in flight.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int TW   = 4,
  parameter int LAT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [TW-1:0]   alu_type_q, alu_type_d;
  logic            alu_valid_q, alu_valid_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
  // Fixed priority needs no rotation pointer.
`else
  logic [PW-1:0]   ptr_q, ptr_d;
`endif

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;

  // Per-requester views of the packed operand buses.
  logic [W-1:0]  a_arr    [NREQ];
  logic [W-1:0]  b_arr    [NREQ];
  logic [TW-1:0] type_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]    = bus.req_a[gi*W +: W];
      assign b_arr[gi]    = bus.req_b[gi*W +: W];
      assign type_arr[gi] = bus.req_type[gi*TW +: TW];
    end
  endgenerate

  // Winner selection among the currently asserted requests.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`else
    // Search starts one past the previous winner and wraps around.
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  // Next-state and output logic; grant/response strobes default low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    gnt_d       = '0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_type_d  = alu_type_q;
    alu_valid_d = alu_valid_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = BUSY;
          cnt_d       = CW'(LAT);
          win_d       = win_idx;
          gnt_d       = NREQ'(1) << win_idx;
          alu_a_d     = a_arr[win_idx];
          alu_b_d     = b_arr[win_idx];
          alu_type_d  = type_arr[win_idx];
          alu_valid_d = 1'b1;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
          ptr_d       = win_idx;
`endif
        end
      end
      BUSY: begin
        // Requests are ignored while the ALU is occupied.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = IDLE;
          rsp_valid_d = NREQ'(1) << win_q;
          rsp_data_d  = bus.alu_c;
          alu_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_type_q  <= '0;
      alu_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      ptr_q       <= PW'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_type_q  <= alu_type_d;
      alu_valid_q <= alu_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_type  = alu_type_q;
  assign bus.alu_valid = alu_valid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiter instances (LAT=1 and LAT=3) against a
// transaction-level model (grant edge + LAT = response edge), checked every
// cycle, plus directed scenarios with literal expectations.
// Honours ALU_ARBITER_FIXED_PRIO_EN for the expected grant orders.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TW   = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .W(W), .TW(TW)) bus0 ();
  alu_arbiter_if #(.NREQ(NREQ), .W(W), .TW(TW)) bus1 ();

  alu_arbiter #(.NREQ(NREQ), .W(W), .TW(TW), .LAT(LAT0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  alu_arbiter #(.NREQ(NREQ), .W(W), .TW(TW), .LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  // Simple ALU used as the environment for both instances.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [TW-1:0] t);
    case (t)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b + 32'd1;
    endcase
  endfunction

  assign bus0.alu_c = alu_f(bus0.alu_a, bus0.alu_b, bus0.alu_type);
  assign bus1.alu_c = alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_type);

  // Stimulus storage, index 0 -> LAT=1 instance, index 1 -> LAT=3 instance.
  logic [NREQ-1:0] req_v [2];
  logic [W-1:0]    a_v   [2][NREQ];
  logic [W-1:0]    b_v   [2][NREQ];
  logic [TW-1:0]   t_v   [2][NREQ];

  assign bus0.req = req_v[0];
  assign bus1.req = req_v[1];
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pack
      assign bus0.req_a[gi*W +: W]     = a_v[0][gi];
      assign bus0.req_b[gi*W +: W]     = b_v[0][gi];
      assign bus0.req_type[gi*TW +: TW] = t_v[0][gi];
      assign bus1.req_a[gi*W +: W]     = a_v[1][gi];
      assign bus1.req_b[gi*W +: W]     = b_v[1][gi];
      assign bus1.req_type[gi*TW +: TW] = t_v[1][gi];
    end
  endgenerate

  // DUT outputs gathered per instance.
  logic [NREQ-1:0] gnt_o [2];
  logic [NREQ-1:0] rsp_o [2];
  logic            av_o  [2];
  logic [W-1:0]    a_o   [2];
  logic [W-1:0]    b_o   [2];
  logic [TW-1:0]   t_o   [2];
  logic [W-1:0]    dat_o [2];
  assign gnt_o[0] = bus0.gnt;       assign gnt_o[1] = bus1.gnt;
  assign rsp_o[0] = bus0.rsp_valid; assign rsp_o[1] = bus1.rsp_valid;
  assign av_o[0]  = bus0.alu_valid; assign av_o[1]  = bus1.alu_valid;
  assign a_o[0]   = bus0.alu_a;     assign a_o[1]   = bus1.alu_a;
  assign b_o[0]   = bus0.alu_b;     assign b_o[1]   = bus1.alu_b;
  assign t_o[0]   = bus0.alu_type;  assign t_o[1]   = bus1.alu_type;
  assign dat_o[0] = bus0.rsp_data;  assign dat_o[1] = bus1.rsp_data;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction-level model: a grant at edge c promises a response at edge c+LAT.
  int              cyc = 0;
  bit              started = 1'b0;
  logic [NREQ-1:0] m_gnt [2];
  logic [NREQ-1:0] m_rsp [2];
  logic            m_av  [2];
  logic [W-1:0]    m_a   [2];
  logic [W-1:0]    m_b   [2];
  logic [TW-1:0]   m_t   [2];
  logic [W-1:0]    m_dat [2];
  int              m_ptr [2];
  bit              m_pend[2];
  int              m_due [2];
  int              m_w   [2];

  always @(posedge clk) begin : model
    cyc     <= cyc + 1;
    started <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      int w;
      w = -1;
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      for (int k = NREQ - 1; k >= 0; k--)
        if (req_v[d][k]) w = k;
`else
      for (int k = NREQ; k >= 1; k--)
        if (req_v[d][(m_ptr[d] + k) % NREQ]) w = (m_ptr[d] + k) % NREQ;
`endif
      if (rst) begin
        m_gnt[d] <= '0; m_rsp[d] <= '0; m_av[d] <= 1'b0;
        m_a[d] <= '0; m_b[d] <= '0; m_t[d] <= '0; m_dat[d] <= '0;
        m_ptr[d] <= NREQ - 1; m_pend[d] <= 1'b0; m_due[d] <= 0; m_w[d] <= 0;
      end else begin
        m_gnt[d] <= '0;
        m_rsp[d] <= '0;
        if (m_pend[d]) begin
          if (cyc == m_due[d]) begin
            m_rsp[d]  <= NREQ'(1) << m_w[d];
            m_dat[d]  <= alu_f(m_a[d], m_b[d], m_t[d]);
            m_av[d]   <= 1'b0;
            m_pend[d] <= 1'b0;
          end
        end else if (w >= 0) begin
          m_gnt[d]  <= NREQ'(1) << w;
          m_a[d]    <= a_v[d][w];
          m_b[d]    <= b_v[d][w];
          m_t[d]    <= t_v[d][w];
          m_av[d]   <= 1'b1;
          m_pend[d] <= 1'b1;
          m_due[d]  <= cyc + ((d == 0) ? LAT0 : LAT1);
          m_w[d]    <= w;
          m_ptr[d]  <= w;
        end
      end
    end
  end

  // Per-cycle comparison against the model plus protocol invariants.
  logic prev_av [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin : compare
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("i%0d.gnt", d),       64'(gnt_o[d]), 64'(m_gnt[d]));
        chk($sformatf("i%0d.rsp_valid", d), 64'(rsp_o[d]), 64'(m_rsp[d]));
        chk($sformatf("i%0d.alu_valid", d), 64'(av_o[d]),  64'(m_av[d]));
        chk($sformatf("i%0d.alu_a", d),     64'(a_o[d]),   64'(m_a[d]));
        chk($sformatf("i%0d.alu_b", d),     64'(b_o[d]),   64'(m_b[d]));
        chk($sformatf("i%0d.alu_type", d),  64'(t_o[d]),   64'(m_t[d]));
        chk($sformatf("i%0d.rsp_data", d),  64'(dat_o[d]), 64'(m_dat[d]));
        chk($sformatf("i%0d.gnt_onehot0", d), 64'($onehot0(gnt_o[d])), 64'(1));
        chk($sformatf("i%0d.rsp_onehot0", d), 64'($onehot0(rsp_o[d])), 64'(1));
        chk($sformatf("i%0d.gnt_with_rsp", d),
            64'((gnt_o[d] != '0) && (rsp_o[d] != '0)), 64'(0));
        chk($sformatf("i%0d.gnt_while_busy", d),
            64'((gnt_o[d] != '0) && prev_av[d]), 64'(0));
        prev_av[d] = av_o[d];
      end
    end
  end

  // Waits (bounded) for the next grant on instance d; idx=-1 on timeout.
  task automatic wait_gnt(input int d, output int idx, output int at);
    idx = -1;
    at  = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt_o[d] != '0) begin
        for (int k = 0; k < NREQ; k++) if (gnt_o[d][k]) idx = k;
        at = cyc;
        $display("inst%0d grant to requester %0d at cycle %0d", d, idx, at);
        return;
      end
    end
    total++;
    $display("FAIL grant_timeout: inst%0d got no grant, required one within 20 cycles", d);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp29 [5];
  int exp30 [4];
  int idx, at, prev_at;

  initial begin : stim
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    exp29 = '{0, 0, 0, 0, 0};
    exp30 = '{1, 1, 1, 1};
`else
    exp29 = '{0, 1, 2, 3, 0};
    exp30 = '{1, 2, 1, 2};
`endif
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0;
      for (int i = 0; i < NREQ; i++) begin
        a_v[d][i] = 32'd100 + 32'(i);
        b_v[d][i] = 32'd7 * 32'(i) + 32'd1;
        t_v[d][i] = TW'(i);
      end
    end

    // Reset held for 5 cycles; everything must read zero.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_gnt%0d", d),  64'(gnt_o[d]), 64'(0));
      chk($sformatf("reset_av%0d", d),   64'(av_o[d]),  64'(0));
      chk($sformatf("reset_a%0d", d),    64'(a_o[d]),   64'(0));
      chk($sformatf("reset_data%0d", d), 64'(dat_o[d]), 64'(0));
    end
    $display("reset released at cycle %0d", cyc);

    // Single add on the LAT=1 instance: 3+5 -> 8 one cycle after grant.
    a_v[0][0] = 32'd3; b_v[0][0] = 32'd5; t_v[0][0] = 4'd0;
    rst = 1'b0;
    req_v[0] = 4'b0001;
    @(negedge clk);
    chk("add_gnt",   64'(gnt_o[0]), 64'h1);
    chk("add_alu_a", 64'(a_o[0]),   64'd3);
    chk("add_alu_b", 64'(b_o[0]),   64'd5);
    chk("add_av",    64'(av_o[0]),  64'd1);
    req_v[0] = '0;
    @(negedge clk);
    chk("add_rsp",   64'(rsp_o[0]), 64'h1);
    chk("add_data",  64'(dat_o[0]), 64'd8);
    chk("add_av_lo", 64'(av_o[0]),  64'd0);
    $display("add transaction: rsp_valid=%b rsp_data=%0d", rsp_o[0], dat_o[0]);

    // All four requesting continuously: order and spacing of grants.
    rst_pulse();
    req_v[0] = 4'b1111;
    prev_at = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(0, idx, at);
      chk($sformatf("rr_order%0d", g), 64'(idx), 64'(exp29[g]));
      if (g > 0) chk($sformatf("rr_spacing%0d", g), 64'(at - prev_at), 64'(LAT0 + 1));
      prev_at = at;
    end
    req_v[0] = '0;
    repeat (3) @(negedge clk);

    // Requesters 1 and 2 contending.
    req_v[0] = 4'b0110;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(0, idx, at);
      chk($sformatf("pair_order%0d", g), 64'(idx), 64'(exp30[g]));
    end
    req_v[0] = '0;
    repeat (3) @(negedge clk);

    // Assorted operations and request patterns, checked by the model.
    for (int v = 0; v < 6; v++) begin
      logic [NREQ-1:0] pats [6];
      pats = '{4'b1000, 4'b0101, 4'b1010, 4'b0011, 4'b1111, 4'b0100};
      for (int i = 0; i < NREQ; i++) begin
        a_v[0][i] = 32'hF000_0000 + 32'(v * 17 + i);
        b_v[0][i] = 32'h0000_0F0F * 32'(i + 1);
        t_v[0][i] = TW'((v + i) % 6);
      end
      req_v[0] = pats[v];
      wait_gnt(0, idx, at);
      req_v[0] = '0;
      @(negedge clk);
      $display("vector %0d: rsp_valid=%b rsp_data=%h", v, rsp_o[0], dat_o[0]);
    end

    // LAT=3: requester 2 adds 10+20; requester 0 arrives one cycle later.
    rst_pulse();
    a_v[1][2] = 32'd10; b_v[1][2] = 32'd20; t_v[1][2] = 4'd0;
    a_v[1][0] = 32'd7;  b_v[1][0] = 32'd2;  t_v[1][0] = 4'd1;
    req_v[1] = 4'b0100;
    @(negedge clk);
    chk("l3_gnt",  64'(gnt_o[1]), 64'h4);
    chk("l3_av0",  64'(av_o[1]),  64'd1);
    req_v[1] = 4'b0001;
    @(negedge clk);
    chk("l3_av1",  64'(av_o[1]),  64'd1);
    chk("l3_gnt1", 64'(gnt_o[1]), 64'h0);
    @(negedge clk);
    chk("l3_av2",  64'(av_o[1]),  64'd1);
    @(negedge clk);
    chk("l3_av3",  64'(av_o[1]),  64'd0);
    chk("l3_rsp",  64'(rsp_o[1]), 64'h4);
    chk("l3_data", 64'(dat_o[1]), 64'd30);
    chk("l3_gnt3", 64'(gnt_o[1]), 64'h0);
    @(negedge clk);
    chk("l3_gnt_next", 64'(gnt_o[1]), 64'h1);
    chk("l3_alu_a0",   64'(a_o[1]),   64'd7);
    req_v[1] = '0;
    repeat (3) @(negedge clk);
    chk("l3_rsp0",  64'(rsp_o[1]), 64'h1);
    chk("l3_data0", 64'(dat_o[1]), 64'd5);
    $display("LAT3 transactions: second rsp_data=%0d", dat_o[1]);

    // Reset while BUSY aborts the operation and restores the pointer.
    a_v[1][1] = 32'd4; b_v[1][1] = 32'd4; t_v[1][1] = 4'd0;
    req_v[1] = 4'b0010;
    @(negedge clk);
    chk("abort_gnt", 64'(gnt_o[1]), 64'h2);
    req_v[1] = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("abort_gnt_z%0d", n),  64'(gnt_o[1]), 64'd0);
      chk($sformatf("abort_rsp_z%0d", n),  64'(rsp_o[1]), 64'd0);
      chk($sformatf("abort_av_z%0d", n),   64'(av_o[1]),  64'd0);
      chk($sformatf("abort_a_z%0d", n),    64'(a_o[1]),   64'd0);
      chk($sformatf("abort_b_z%0d", n),    64'(b_o[1]),   64'd0);
      chk($sformatf("abort_t_z%0d", n),    64'(t_o[1]),   64'd0);
      chk($sformatf("abort_data_z%0d", n), 64'(dat_o[1]), 64'd0);
      @(negedge clk);
    end
    repeat (3) begin
      chk("abort_no_rsp", 64'(rsp_o[1]), 64'd0);
      @(negedge clk);
    end
    req_v[1] = 4'b1111;
    @(negedge clk);
    chk("abort_next_gnt", 64'(gnt_o[1]), 64'h1);
    req_v[1] = '0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing the single ALU (2..8) SHALL be supported.
REQ-002 Parameter W, 32, operand/result width SHALL be supported.
REQ-003 Parameter TW, 4, ALU operation-type width SHALL be supported.
REQ-004 Parameter LAT, 1, ALU latency in cycles from operand issue to valid alu_c (LAT>=1) SHALL be supported.
REQ-005 Port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port req  input  NREQ  per-requester request, level, held until gnt.
REQ-008 Port req_a / req_b  input  NREQ*W  packed operands; slice i belongs to requester i.
REQ-009 Port req_type  input  NREQ*TW  packed operation type.
REQ-010 Port gnt  output  NREQ  one-hot, one-cycle acceptance pulse.
REQ-011 Port alu_a / alu_b  output  W  operands to ALU; alu_type  output  TW  type to ALU.
REQ-012 Port alu_valid  output  1  operation in flight; alu_c  input  W  ALU result.
REQ-013 Port rsp_valid  output  NREQ  one-hot, one-cycle result strobe; rsp_data  output  W  result.

Function
REQ-014 States SHALL be IDLE and BUSY only; one operation in flight at most.
REQ-015 IDLE with req!=0 at an edge: SHALL pick winner w, register alu_a/b/type from slice w, set gnt[w]=1 and alu_valid=1, load cnt=LAT, go BUSY.
REQ-016 IDLE with req==0: SHALL stay IDLE, gnt=0, alu_valid=0, alu_* hold last values.
REQ-017 BUSY: req SHALL be ignored; gnt=0; cnt decrements each edge.
REQ-018 BUSY edge with cnt==1: SHALL register rsp_data=alu_c, rsp_valid[w]=1 for one cycle, alu_valid=0, go IDLE.
REQ-019 Timing: gnt and alu_valid at edge E; rsp_valid at edge E+LAT; next gnt earliest at E+LAT+1 (throughput one op per LAT+1 cycles).
REQ-020 Arbitration SHALL be round-robin: search starts at index ptr+1 mod NREQ; ptr updates to w on each grant.
REQ-021 Requester SHALL deassert or change req in the cycle after gnt; a still-asserted req at next IDLE is treated as a new request.
REQ-022 rsp_valid and a new gnt MAY occur on consecutive edges but never on the same edge.
REQ-023 gnt and rsp_valid SHALL each have at most one bit set at any time.

Reset
REQ-024 rst at any edge SHALL force IDLE, cnt=0, ptr=NREQ-1, gnt=0, rsp_valid=0, alu_valid=0, alu_a=alu_b=0, alu_type=0, rsp_data=0.
REQ-025 rst during BUSY SHALL abort the operation; no rsp_valid SHALL be issued for it.

Configuration
REQ-026 Macro ALU_ARBITER_FIXED_PRIO_EN defined: winner SHALL be lowest-index asserted req; ptr unused.
REQ-027 Macro ALU_ARBITER_FIXED_PRIO_EN undefined: round-robin per REQ-020.

Verification
REQ-028 LAT=1, rst 5 cycles, req[0]=1 with a=3,b=5,type=0, ALU adds -> gnt=0001 at E, alu_a=3, alu_b=5, rsp_valid=0001, rsp_data=8 at E+1.
REQ-029 Default build, req=1111 held, each requester re-requests after its gnt -> grant order 0,1,2,3,0 at spacing LAT+1 cycles.
REQ-030 ALU_ARBITER_FIXED_PRIO_EN defined, req=0110 held -> requester 1 granted every time, requester 2 never.
REQ-031 LAT=3, req[2]=1 a=10,b=20 -> alu_valid high 3 cycles, rsp_valid=0100, rsp_data=30 at E+3, req arriving at E+1 for requester 0 granted at E+4.
REQ-032 rst asserted at E+1 with LAT=3 -> no rsp_valid, all outputs 0 at E+2, ptr=NREQ-1 so next simultaneous req=1111 grants requester 0.
REQ-033 Checker throughout: gnt and rsp_valid one-hot-or-zero, no gnt while alu_valid=1.
